// File: rtl/seg_msg_scroller_if.sv
// Display bundle for seg_msg_scroller: state select in, anodes/segments/wrap pulse out.
// Ports: estado (pet state), an (active-low anodes), seg (active-low a..g), scroll_wrap.
// The master side drives estado; the slave side (the scroller) drives the display.
interface seg_msg_scroller_if #(
    parameter int N_DIGITS = 8
);
    logic [2:0]          estado;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;
    logic                scroll_wrap;

    modport master (output estado, input an, input seg, input scroll_wrap);
    modport slave  (input estado, output an, output seg, output scroll_wrap);
endinterface

// File: rtl/seg_msg_scroller.sv
// Multiplexed seven-segment message scroller: shows a pet-state message, optionally scrolling.
// Ports: clk, rst (async active-high), bus.slave (estado in; an, seg, scroll_wrap out, all registered).
// Latency estado pin -> an/seg is 2 cycles; no backpressure. Scrolling exists only with SEG_MSG_SCROLL_EN.
module seg_msg_scroller #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 1200,
    parameter int SCROLL_DIV  = 12000000,
    parameter int MSG_LEN     = 16
) (
    input  logic             clk,
    input  logic             rst,
    seg_msg_scroller_if.slave bus
);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int SEL_W = $clog2(N_DIGITS);
    localparam int OFF_W = $clog2(MSG_LEN);

    generate
        if (N_DIGITS < 2 || N_DIGITS > 8 || REFRESH_DIV < 2 || SCROLL_DIV < 2 ||
            MSG_LEN < N_DIGITS || MSG_LEN < 8 || MSG_LEN > 32) begin : g_bad_params
            $error("seg_msg_scroller: illegal parameter combination");
        end
    endgenerate

    // Messages are stored left-aligned, 8 glyph slots each; any slot beyond that is blank.
    function automatic logic [4:0] msg_glyph(input logic [2:0] st, input logic [5:0] idx);
        logic [39:0] m;
        logic [39:0] sh;
        case (st)
            3'd2:    m = {5'd5,  5'd1,  5'd6,  5'd7,  5'd8,  5'd9,  5'd31, 5'd31}; // NEUTRO
            3'd3:    m = {5'd10, 5'd11, 5'd12, 5'd13, 5'd8,  5'd1,  5'd31, 5'd31}; // HAMBRE
            3'd4:    m = {5'd14, 5'd1,  5'd15, 5'd16, 5'd11, 5'd5,  5'd15, 5'd9};  // DESCANSO
            3'd5:    m = {5'd12, 5'd6,  5'd1,  5'd8,  5'd7,  5'd9,  5'd31, 5'd31}; // MUERTO
            3'd6:    m = {5'd11, 5'd12, 5'd3,  5'd15, 5'd7,  5'd11, 5'd14, 5'd31}; // AMISTAD
            default: m = {5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd31, 5'd31, 5'd31}; // FELIZ
        endcase
        sh = m << (5 * int'(idx[2:0]));
        if (idx < 6'd8) msg_glyph = sh[39 -: 5];
        else            msg_glyph = 5'd31;
    endfunction

    // Active-low segment patterns, bit 0 = a.
    function automatic logic [6:0] seg_decode(input logic [4:0] g);
        case (g)
            5'd0:    seg_decode = 7'h0E; // F
            5'd1:    seg_decode = 7'h06; // E
            5'd2:    seg_decode = 7'h47; // L
            5'd3:    seg_decode = 7'h79; // I
            5'd4:    seg_decode = 7'h24; // Z
            5'd5:    seg_decode = 7'h48; // N
            5'd6:    seg_decode = 7'h41; // U
            5'd7:    seg_decode = 7'h07; // t
            5'd8:    seg_decode = 7'h2F; // r
            5'd9:    seg_decode = 7'h40; // O
            5'd10:   seg_decode = 7'h09; // H
            5'd11:   seg_decode = 7'h08; // A
            5'd12:   seg_decode = 7'h6A; // M
            5'd13:   seg_decode = 7'h03; // b
            5'd14:   seg_decode = 7'h21; // d
            5'd15:   seg_decode = 7'h12; // S
            5'd16:   seg_decode = 7'h46; // C
            default: seg_decode = 7'h7F; // blank
        endcase
    endfunction

    logic [2:0]          r_estado_q;
    logic [REF_W-1:0]    r_refresh;
    logic [SEL_W-1:0]    r_sel;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic [OFF_W-1:0]    w_offset;
    logic                w_wrap;
    logic [OFF_W:0]      w_idx_raw;
    logic [OFF_W:0]      w_idx;
    logic [N_DIGITS-1:0] w_an_lit;
    logic [6:0]          w_seg_lit;

    // offset + sel never reaches 2*MSG_LEN, so one conditional subtract is the modulo.
    assign w_idx_raw = (OFF_W+1)'(w_offset) + (OFF_W+1)'(r_sel);
    assign w_idx     = (w_idx_raw >= (OFF_W+1)'(MSG_LEN)) ? w_idx_raw - (OFF_W+1)'(MSG_LEN) : w_idx_raw;
    assign w_seg_lit = seg_decode(msg_glyph(r_estado_q, 6'(w_idx)));
    // Digit 0 is the leftmost, driven on the top anode bit.
    assign w_an_lit  = ~(N_DIGITS'(1) << (N_DIGITS - 1 - int'(r_sel)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado_q <= 3'd0;
            r_refresh  <= '0;
            r_sel      <= '0;
            r_an       <= '1;
            r_seg      <= 7'h7F;
        end else begin
            r_estado_q <= bus.estado;
            if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_sel     <= (r_sel == SEL_W'(N_DIGITS - 1)) ? '0 : r_sel + SEL_W'(1);
            end else begin
                r_refresh <= r_refresh + REF_W'(1);
            end
            // First count of each slot is dark so the previous digit's glyph never ghosts onto the new anode.
            if (r_refresh == '0) begin
                r_an  <= '1;
                r_seg <= 7'h7F;
            end else begin
                r_an  <= w_an_lit;
                r_seg <= w_seg_lit;
            end
        end
    end

`ifdef SEG_MSG_SCROLL_EN
    localparam int SCR_W = $clog2(SCROLL_DIV);

    logic [2:0]       r_estado_prev;
    logic [SCR_W-1:0] r_scroll_cnt;
    logic [OFF_W-1:0] r_offset;
    logic             r_wrap;
    logic             w_chg;
    logic             w_step;

    assign w_chg  = (r_estado_q != r_estado_prev);
    assign w_step = (r_scroll_cnt == SCR_W'(SCROLL_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado_prev <= 3'd0;
            r_scroll_cnt  <= '0;
            r_offset      <= '0;
            r_wrap        <= 1'b0;
        end else begin
            r_estado_prev <= r_estado_q;
            r_wrap        <= 1'b0;
            // A new message always starts from its first glyph, even if a step was due.
            if (w_chg) begin
                r_scroll_cnt <= '0;
                r_offset     <= '0;
            end else if (w_step) begin
                r_scroll_cnt <= '0;
                if (r_offset == OFF_W'(MSG_LEN - 1)) begin
                    r_offset <= '0;
                    r_wrap   <= 1'b1;
                end else begin
                    r_offset <= r_offset + OFF_W'(1);
                end
            end else begin
                r_scroll_cnt <= r_scroll_cnt + SCR_W'(1);
            end
        end
    end

    assign w_offset = r_offset;
    assign w_wrap   = r_wrap;
`else
    assign w_offset = '0;
    assign w_wrap   = 1'b0;
`endif

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.scroll_wrap = w_wrap;
endmodule

// File: tb/tb_seg_msg_scroller.sv
// Directed self-checking bench for seg_msg_scroller (N_DIGITS=4, REFRESH_DIV=4, SCROLL_DIV=32, MSG_LEN=8).
// Cycle k = k-th rising edge after reset release; outputs are sampled on the falling edge after it.
// Scroll scenarios run when SEG_MSG_SCROLL_EN is defined, the static scenario otherwise.
module tb_seg_msg_scroller;
    localparam logic [6:0] G_F = 7'h0E, G_E = 7'h06, G_L = 7'h47, G_I = 7'h79;
    localparam logic [6:0] G_N = 7'h48, G_U = 7'h41, G_T = 7'h07, G_R = 7'h2F;
    localparam logic [6:0] G_O = 7'h40, G_H = 7'h09, G_A = 7'h08, G_M = 7'h6A;
    localparam logic [6:0] G_D = 7'h21, G_S = 7'h12, G_C = 7'h46, G_BL = 7'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seg_msg_scroller_if #(.N_DIGITS(4)) bus ();

    seg_msg_scroller #(
        .N_DIGITS(4), .REFRESH_DIV(4), .SCROLL_DIV(32), .MSG_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] st);
        bus.estado = st;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scan pattern: one dark cycle then three lit cycles per digit, digit 0 first.
    function automatic bit is_gap(input int k);
        return ((k - 1) % 4) == 0;
    endfunction

    function automatic int digit_of(input int k);
        return ((k - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] a;
        a = 4'b1000 >> digit_of(k);
        if (is_gap(k)) return 4'b1111;
        return ~a;
    endfunction

    task automatic test_reset();
        do_reset(3'd1);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.an !== 4'b1111) begin failures++; $display("FAIL reset_async_an got=%b want=1111", bus.an); end
        checks++;
        if (bus.seg !== 7'h7F) begin failures++; $display("FAIL reset_async_seg got=%h want=7f", bus.seg); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.scroll_wrap !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d an=%b seg=%h wrap=%b want 1111/7f/0", i, bus.an, bus.seg, bus.scroll_wrap);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.an !== 4'b1111) begin failures++; $display("FAIL reset_first_gap got=%b want=1111", bus.an); end
        tick();
        checks++;
        if (bus.an !== 4'b0111) begin failures++; $display("FAIL reset_first_digit an got=%b want=0111", bus.an); end
        checks++;
        if (bus.seg !== G_F) begin failures++; $display("FAIL reset_first_digit seg got=%h want=%h", bus.seg, G_F); end
    endtask

    task automatic test_scan();
        logic [6:0] g [4] = '{G_F, G_E, G_L, G_I};
        logic [6:0] want_seg;
        do_reset(3'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            want_seg = is_gap(k) ? G_BL : g[digit_of(k)];
            checks++;
            if (bus.an !== exp_an(k)) begin failures++; $display("FAIL scan_an k=%0d got=%b want=%b", k, bus.an, exp_an(k)); end
            checks++;
            if (bus.seg !== want_seg) begin failures++; $display("FAIL scan_seg k=%0d got=%h want=%h", k, bus.seg, want_seg); end
        end
    endtask

    // New state every scan frame: FELIZ, NEUTRO, AMISTAD, then 7 falls back to FELIZ.
    task automatic test_back_to_back();
        logic [2:0] st [4] = '{3'd1, 3'd2, 3'd6, 3'd7};
        logic [6:0] tbl [4][4] = '{'{G_F, G_E, G_L, G_I}, '{G_N, G_E, G_U, G_T},
                                   '{G_A, G_M, G_I, G_S}, '{G_F, G_E, G_L, G_I}};
        logic [6:0] want_seg;
        do_reset(3'd1);
        for (int p = 0; p < 4; p++) begin
            bus.estado = st[p];
            for (int k = 16 * p + 1; k <= 16 * p + 16; k++) begin
                tick();
                want_seg = is_gap(k) ? G_BL : tbl[p][digit_of(k)];
                checks++;
                if (bus.an !== exp_an(k) || bus.seg !== want_seg) begin
                    failures++;
                    $display("FAIL b2b st=%0d k=%0d an=%b seg=%h want %b/%h", st[p], k, bus.an, bus.seg, exp_an(k), want_seg);
                end
            end
        end
    endtask

`ifdef SEG_MSG_SCROLL_EN
    task automatic test_scroll();
        logic [6:0] seq [9] = '{G_D, G_E, G_S, G_C, G_A, G_N, G_S, G_O, G_D};
        int wraps = 0;
        int wrap_k = -1;
        do_reset(3'd4);
        for (int k = 1; k <= 280; k++) begin
            tick();
            if (bus.scroll_wrap === 1'b1) begin
                wraps++;
                if (wrap_k < 0) wrap_k = k;
            end
            if (k >= 19 && ((k - 19) % 32) == 0) begin
                checks++;
                if (bus.an !== 4'b0111 || bus.seg !== seq[(k - 19) / 32]) begin
                    failures++;
                    $display("FAIL scroll_left k=%0d an=%b seg=%h want 0111/%h", k, bus.an, bus.seg, seq[(k - 19) / 32]);
                end
            end
        end
        checks++;
        if (wraps != 1) begin failures++; $display("FAIL scroll_wrap_count got=%0d want=1", wraps); end
        checks++;
        if (wrap_k != 258) begin failures++; $display("FAIL scroll_wrap_cycle got=%0d want=258", wrap_k); end
    endtask

    // estado 1->3 lands on the edge where the first scroll step (offset 0->1) is due.
    task automatic test_state_change();
        int wraps = 0;
        do_reset(3'd1);
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 32) bus.estado = 3'd3;
            if (bus.scroll_wrap === 1'b1) wraps++;
            if (k == 35 || k == 51) begin
                checks++;
                if (bus.an !== 4'b0111 || bus.seg !== G_H) begin
                    failures++;
                    $display("FAIL chg_left k=%0d an=%b seg=%h want 0111/%h", k, bus.an, bus.seg, G_H);
                end
            end
            if (k == 67) begin
                checks++;
                if (bus.seg !== G_A) begin failures++; $display("FAIL chg_restep k=67 seg=%h want=%h", bus.seg, G_A); end
            end
        end
        checks++;
        if (wraps != 0) begin failures++; $display("FAIL chg_no_wrap got=%0d want=0", wraps); end
    endtask

    // estado change coincides with the offset 7->0 step: the wrap pulse must be suppressed.
    task automatic test_change_at_wrap();
        int wraps = 0;
        do_reset(3'd1);
        for (int k = 1; k <= 270; k++) begin
            tick();
            if (k == 256) bus.estado = 3'd3;
            if (bus.scroll_wrap === 1'b1) wraps++;
            if (k == 259) begin
                checks++;
                if (bus.seg !== G_H) begin failures++; $display("FAIL wrapchg_left k=259 seg=%h want=%h", bus.seg, G_H); end
            end
        end
        checks++;
        if (wraps != 0) begin failures++; $display("FAIL wrapchg_no_wrap got=%0d want=0", wraps); end
    endtask

    // Offset 5 of FELIZ: slots 5..7 are blank, slot 0 (F) lands on digit 3.
    task automatic test_blank_glyphs();
        logic [6:0] g [4] = '{G_BL, G_BL, G_BL, G_F};
        logic [6:0] want_seg;
        do_reset(3'd1);
        for (int k = 1; k <= 192; k++) begin
            tick();
            if (k >= 177) begin
                want_seg = is_gap(k) ? G_BL : g[digit_of(k)];
                checks++;
                if (bus.an !== exp_an(k) || bus.seg !== want_seg) begin
                    failures++;
                    $display("FAIL blank k=%0d an=%b seg=%h want %b/%h", k, bus.an, bus.seg, exp_an(k), want_seg);
                end
            end
        end
    endtask
`else
    task automatic test_static();
        logic [6:0] g [4] = '{G_M, G_U, G_E, G_R};
        logic [6:0] want_seg;
        do_reset(3'd5);
        for (int k = 1; k <= 1000; k++) begin
            tick();
            want_seg = is_gap(k) ? G_BL : g[digit_of(k)];
            checks++;
            if (bus.an !== exp_an(k) || bus.seg !== want_seg) begin
                failures++;
                $display("FAIL static k=%0d an=%b seg=%h want %b/%h", k, bus.an, bus.seg, exp_an(k), want_seg);
            end
            checks++;
            if (bus.scroll_wrap !== 1'b0) begin failures++; $display("FAIL static_wrap k=%0d got=%b want=0", k, bus.scroll_wrap); end
        end
    endtask
`endif

    initial begin
        bus.estado = 3'd1;
        test_reset();
        test_scan();
        test_back_to_back();
`ifdef SEG_MSG_SCROLL_EN
        test_scroll();
        test_state_change();
        test_change_at_wrap();
        test_blank_glyphs();
`else
        test_static();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
